// File: rtl/nop_pkg.sv
// Shared helpers for the NoP router slice: constant log2 and per-VC count-vector slicing.
package nop_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // LSB of VC v's occupancy field inside the flat count vector.
  function automatic int unsigned count_lsb(input int unsigned vc, input int unsigned addr_width);
    return vc * (addr_width + 1);
  endfunction

endpackage

// File: rtl/sync_dualport_ram.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
module sync_dualport_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register resets to zero and holds between accepted reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/multi_vc_fifo.sv
// Single-clock multi-VC FIFO: NUM_VC independent queues sharing one RAM, with per-VC flags and sticky errors.
module multi_vc_fifo
  import nop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned NUM_VC       = 4,
  parameter int unsigned VC_WIDTH     = 2,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [VC_WIDTH-1:0]              wr_vc,
  input  logic                             wr_en,
  input  logic [VC_WIDTH-1:0]              rd_vc,
  input  logic                             rd_en,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                afull,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count,
  output logic [NUM_VC-1:0]                err_overflow,
  output logic [NUM_VC-1:0]                err_underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [NUM_VC-1:0]     wr_sel, rd_sel, wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0] wr_ptr_sel, rd_ptr_sel;
  logic                  ram_we, ram_re;

  // One-hot VC decode: an out-of-range index matches no VC, so the request is silently ignored.
  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [ADDR_WIDTH-1:0] wp, rp;
      logic [CW-1:0]         cnt;
      logic                  ovf, udf;

      assign wr_sel[v] = wr_en && (wr_vc == VC_WIDTH'(v));
      assign rd_sel[v] = rd_en && (rd_vc == VC_WIDTH'(v));
      assign wr_acc[v] = wr_sel[v] & ~full[v];
      assign rd_acc[v] = rd_sel[v] & ~empty[v];

      assign full[v]  = (cnt == CW'(DEPTH));
      assign empty[v] = (cnt == '0);
      assign afull[v] = (cnt >= CW'(AFULL_THRESH));
      assign count[count_lsb(v, ADDR_WIDTH) +: CW] = cnt;
      assign err_overflow[v]  = ovf;
      assign err_underflow[v] = udf;
      assign wr_ptr_q[v] = wp;
      assign rd_ptr_q[v] = rp;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wp  <= '0;
          rp  <= '0;
          cnt <= '0;
          ovf <= 1'b0;
          udf <= 1'b0;
        end else begin
          if (wr_acc[v]) wp <= wp + 1'b1;
          if (rd_acc[v]) rp <= rp + 1'b1;
          case ({wr_acc[v], rd_acc[v]})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
          endcase
          if (wr_sel[v] && full[v])  ovf <= 1'b1;
          if (rd_sel[v] && empty[v]) udf <= 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (wr_sel[v]) wr_ptr_sel = wr_ptr_q[v];
      if (rd_sel[v]) rd_ptr_sel = rd_ptr_q[v];
    end
  end

  assign ram_we = |wr_acc;
  assign ram_re = |rd_acc;

  // A same-address write/read collision cannot occur: equal pointers mean the VC is empty or full.
  sync_dualport_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH + VC_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rstn (rstn),
    .we   (ram_we),
    .waddr({wr_vc, wr_ptr_sel}),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr({rd_vc, rd_ptr_sel}),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_valid <= 1'b0;
    else       rd_valid <= ram_re;
  end

endmodule

// File: tb/tb_multi_vc_fifo.sv
// Randomized scoreboard bench for multi_vc_fifo against a queue-based reference model.
module tb_multi_vc_fifo;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int NV    = 4;
  localparam int VW    = 2;
  localparam int AT    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = AW + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DW-1:0]     wr_data = '0;
  logic [VW-1:0]     wr_vc = '0;
  logic              wr_en = 1'b0;
  logic [VW-1:0]     rd_vc = '0;
  logic              rd_en = 1'b0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic [NV-1:0]     full, afull, empty, err_overflow, err_underflow;
  logic [NV*CW-1:0]  count;

  multi_vc_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV), .VC_WIDTH(VW), .AFULL_THRESH(AT)
  ) dut (
    .clk(clk), .rstn(rstn), .wr_data(wr_data), .wr_vc(wr_vc), .wr_en(wr_en),
    .rd_vc(rd_vc), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .afull(afull), .empty(empty), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: one plain queue per VC plus the expected read-output queue.
  logic [DW-1:0] mq [NV][$];
  logic [DW-1:0] exp_q [$];
  logic          exp_valid = 1'b0;
  logic [NV-1:0] m_ovf = '0, m_udf = '0;
  int            n_cmp = 0, n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit we, input int wvc, input logic [DW-1:0] wd,
                      input bit re, input int rvc);
    bit wok, rok;
    wr_en = we; wr_vc = wvc[VW-1:0]; wr_data = wd;
    rd_en = re; rd_vc = rvc[VW-1:0];
    @(posedge clk);
    wok = we && (wvc < NV) && (mq[wvc].size() < DEPTH);
    rok = re && (rvc < NV) && (mq[rvc].size() > 0);
    if (we && (wvc < NV) && !wok) m_ovf[wvc] = 1'b1;
    if (re && (rvc < NV) && !rok) m_udf[rvc] = 1'b1;
    if (rok) exp_q.push_back(mq[rvc].pop_front());
    exp_valid = rok;
    if (wok) mq[wvc].push_back(wd);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mq[v].delete();
    exp_q.delete();
    exp_valid = 1'b0;
    m_ovf = '0;
    m_udf = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 4'hF);
    check({tag, "_full"}, full, 0);
    check({tag, "_afull"}, afull, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_ovf"}, err_overflow, 0);
    check({tag, "_udf"}, err_underflow, 0);
  endtask

  // Monitor: every cycle compare the popped flit and all per-VC status against the model.
  always @(negedge clk) begin
    if (rstn) begin
      check("rd_valid", rd_valid, exp_valid);
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_valid) check("rd_data", rd_data, e);
      end
      for (int v = 0; v < NV; v++) begin
        int sz;
        sz = mq[v].size();
        check($sformatf("count%0d", v), count[v*CW +: CW], sz);
        check($sformatf("empty%0d", v), empty[v], sz == 0);
        check($sformatf("full%0d", v), full[v], sz == DEPTH);
        check($sformatf("afull%0d", v), afull[v], sz >= AT);
      end
      check("err_overflow", err_overflow, m_ovf);
      check("err_underflow", err_underflow, m_udf);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    #2 rstn = 1'b1;

    // Fill VC2, overflow write, drain.
    for (int i = 0; i < 4; i++) step(1, 2, 16'hA0 + 16'(i), 0, 0);
    step(1, 2, 16'hFF, 0, 0);
    @(negedge clk);
    check("ovf_vc2", err_overflow, 4'b0100);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0);

    // VC1 steady state at count 2 with simultaneous write+read.
    step(1, 1, 16'h100, 0, 0);
    step(1, 1, 16'h101, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 16'h102 + 16'(i), 1, 1);
    @(negedge clk);
    check("vc1_count_hold", count[1*CW +: CW], 2);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Interleaved writes, then cross-VC reads.
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < NV; v++) step(1, v, 16'h10 * 16'(v + 1) + 16'(i), 0, 0);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 0);
    for (int v = 0; v < NV; v++)
      while (mq[v].size() > 0) step(0, 0, 0, 1, v);
    step(0, 0, 0, 0, 0);

    // Read of empty VC0 coincident with a write: no bypass.
    step(1, 0, 16'h55, 1, 0);
    @(negedge clk);
    check("udf_vc0", err_underflow[0], 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, NV - 1), 16'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, NV - 1));
    for (int v = 0; v < NV; v++)
      while (mq[v].size() > 0) step(0, 0, 0, 1, v);

    // Asynchronous reset with VC0 holding three flits.
    for (int i = 0; i < 3; i++) step(1, 0, 16'h70 + 16'(i), 0, 0);
    step(1, 3, 16'h77, 0, 0);
    @(negedge clk);
    check("pre_reset_count0", count[0 +: CW], 3);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async");
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("post_reset_empty", empty, 4'hF);
    check("post_reset_count", count, 0);

    // Traffic after reset recovers normally.
    step(1, 0, 16'hBEEF, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("pending_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
